// File: rtl/acc_core.sv
// Parametrised accumulator core: fetch/decode/execute FSM, W-bit ALU and registered flags.
// Optional conditional/unconditional branching (opcodes 8-11) is enabled by ACC_CORE_BRANCH_EN.
module acc_core #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic          instr_req,
   output logic [AW-1:0] instr_addr,
   input  logic [W+3:0]  instr_data,
   input  logic          instr_valid,
   output logic [W-1:0]  acc_out,
   output logic          zero_f,
   output logic          carry_f,
   output logic          negative_f,
   output logic          overflow_f,
   output logic          fetch,
   output logic          halted
);

   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_ADD = 4'd0;
   localparam logic [OPW-1:0] OP_SUB = 4'd1;
   localparam logic [OPW-1:0] OP_AND = 4'd2;
   localparam logic [OPW-1:0] OP_OR  = 4'd3;
   localparam logic [OPW-1:0] OP_LDA = 4'd4;
   localparam logic [OPW-1:0] OP_SHL = 4'd5;
   localparam logic [OPW-1:0] OP_SHR = 4'd6;
   localparam logic [OPW-1:0] OP_XOR = 4'd7;
   localparam logic [OPW-1:0] OP_HLT = 4'd15;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [OPW-1:0] ir_op;
   logic [W-1:0]   ir_lit;
   logic [AW-1:0]  pc;
   logic [W-1:0]   acc;
   logic           z_r, c_r, n_r, v_r;

   // Values formed in DECODE, committed in EXECUTE
   logic [W-1:0]   res_q;
   logic           z_q, c_q, n_q, v_q, wr_q, take_q;

   logic [W:0]     sum;
   logic [W-1:0]   diff;
   logic [W-1:0]   alu_res;
   logic           alu_c, alu_v, alu_wr, br_take;
   logic           instr_req_d, fetch_d, halted_d;

   // State register plus registered state outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         instr_req <= 1'b1;
         fetch     <= 1'b1;
         halted    <= 1'b0;
      end else begin
         state     <= state_nxt;
         instr_req <= instr_req_d;
         fetch     <= fetch_d;
         halted    <= halted_d;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:   if (instr_valid) state_nxt = S_DECODE;
         S_DECODE:  state_nxt = S_EXECUTE;
         S_EXECUTE: state_nxt = (ir_op == OP_HLT) ? S_HALT : S_FETCH;
         S_HALT:    state_nxt = S_HALT;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // Outputs are computed from the next state so they register alongside it
   always_comb begin
      instr_req_d = 1'b0;
      fetch_d     = 1'b0;
      halted_d    = 1'b0;
      case (state_nxt)
         S_FETCH: begin
            instr_req_d = 1'b1;
            fetch_d     = 1'b1;
         end
         S_HALT:  halted_d = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      sum     = {1'b0, acc} + {1'b0, ir_lit};
      diff    = acc - ir_lit;
      alu_res = acc;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_wr  = 1'b1;
      case (ir_op)
         OP_ADD: begin
            alu_res = sum[W-1:0];
            alu_c   = sum[W];
            alu_v   = (acc[W-1] == ir_lit[W-1]) && (sum[W-1] != acc[W-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_c   = (acc < ir_lit);
            alu_v   = (acc[W-1] != ir_lit[W-1]) && (diff[W-1] != acc[W-1]);
         end
         OP_AND:  alu_res = acc & ir_lit;
         OP_OR:   alu_res = acc | ir_lit;
         OP_LDA:  alu_res = ir_lit;
         OP_SHL:  alu_res = acc << 1;
         OP_SHR:  alu_res = acc >> 1;
         OP_XOR:  alu_res = acc ^ ir_lit;
         default: alu_wr  = 1'b0;
      endcase
   end

`ifdef ACC_CORE_BRANCH_EN
   // Conditions use the flags as committed by the previous instruction
   always_comb begin
      br_take = 1'b0;
      case (ir_op)
         4'd8:    br_take = 1'b1;
         4'd9:    br_take = z_r;
         4'd10:   br_take = c_r;
         4'd11:   br_take = n_r;
         default: br_take = 1'b0;
      endcase
   end
`else
   assign br_take = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_op  <= '0;
         ir_lit <= '0;
         pc     <= '0;
         acc    <= '0;
         z_r    <= 1'b0;
         c_r    <= 1'b0;
         n_r    <= 1'b0;
         v_r    <= 1'b0;
         res_q  <= '0;
         z_q    <= 1'b0;
         c_q    <= 1'b0;
         n_q    <= 1'b0;
         v_q    <= 1'b0;
         wr_q   <= 1'b0;
         take_q <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (instr_valid) begin
                  ir_op  <= instr_data[W+3:W];
                  ir_lit <= instr_data[W-1:0];
               end
            end
            S_DECODE: begin
               res_q  <= alu_res;
               z_q    <= (alu_res == '0);
               n_q    <= alu_res[W-1];
               c_q    <= alu_c;
               v_q    <= alu_v;
               wr_q   <= alu_wr;
               take_q <= br_take;
            end
            S_EXECUTE: begin
               if (wr_q) begin
                  acc <= res_q;
                  z_r <= z_q;
                  c_r <= c_q;
                  n_r <= n_q;
                  v_r <= v_q;
               end
               if (ir_op != OP_HLT)
                  pc <= take_q ? ir_lit[AW-1:0] : pc + AW'(1);
            end
            default: ;
         endcase
      end
   end

   assign instr_addr = pc;
   assign acc_out    = acc;
   assign zero_f     = z_r;
   assign carry_f    = c_r;
   assign negative_f = n_r;
   assign overflow_f = v_r;

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core (W=8, AW=4) against an instruction-level reference model.
module tb_acc_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [3:0]  instr_addr;
   logic [11:0] instr_data;
   logic        instr_valid;
   logic [7:0]  acc_out;
   logic        zero_f, carry_f, negative_f, overflow_f;
   logic        fetch, halted;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_acc, m_pc;
   bit m_z, m_c, m_n, m_v, m_halt;

`ifdef ACC_CORE_BRANCH_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   acc_core #(.W(8), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_data(instr_data), .instr_valid(instr_valid),
      .acc_out(acc_out),
      .zero_f(zero_f), .carry_f(carry_f), .negative_f(negative_f), .overflow_f(overflow_f),
      .fetch(fetch), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic int sgn8(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   // Executes one instruction on the model from the architectural rules
   task automatic model_exec(input logic [11:0] ins);
      int op, l, r, sr;
      bit taken;
      op = int'(ins[11:8]);
      l  = int'(ins[7:0]);
      taken = 1'b0;
      if (op <= 7) begin
         m_c = 1'b0;
         m_v = 1'b0;
         case (op)
            0: begin
               r = m_acc + l; m_c = (r > 255);
               sr = sgn8(m_acc) + sgn8(l); m_v = (sr > 127) || (sr < -128);
            end
            1: begin
               r = m_acc - l; m_c = (m_acc < l);
               sr = sgn8(m_acc) - sgn8(l); m_v = (sr > 127) || (sr < -128);
            end
            2: r = m_acc & l;
            3: r = m_acc | l;
            4: r = l;
            5: r = m_acc * 2;
            6: r = m_acc / 2;
            default: r = m_acc ^ l;
         endcase
         m_acc = r & 255;
         m_z = (m_acc == 0);
         m_n = (m_acc >= 128);
      end else if (BR_EN && op <= 11) begin
         taken = (op == 8) || (op == 9 && m_z) || (op == 10 && m_c) || (op == 11 && m_n);
      end
      if (op == 15) m_halt = 1'b1;
      else m_pc = taken ? (l % 16) : ((m_pc + 1) % 16);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_acc = 0; m_pc = 0;
      m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_halt = 0;
   endtask

   // Presents one instruction after `waits` idle FETCH cycles and returns at the negedge after commit
   task automatic issue(input logic [11:0] ins, input int waits, input bit junk);
      int guard = 0;
      while (!instr_req && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!instr_req) begin
         checks++; errors++;
         $display("FAIL fetch_timeout: instr_req=%0b required 1", instr_req);
      end
      instr_valid = 1'b0;
      repeat (waits) @(negedge clk);
      instr_valid = 1'b1;
      instr_data  = ins;
      @(negedge clk);
      instr_valid = junk;
      instr_data  = 12'($urandom);
      @(negedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      model_exec(ins);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({instr_req, fetch, halted} !== 3'b110) begin
         errors++;
         $display("FAIL reset_state: req/fetch/halt=%b required 110", {instr_req, fetch, halted});
      end
      checks++;
      if (instr_addr !== 4'h0 || acc_out !== 8'h00) begin
         errors++;
         $display("FAIL reset_regs: addr=%h acc=%h required 0 00", instr_addr, acc_out);
      end
      checks++;
      if ({zero_f, carry_f, negative_f, overflow_f} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: zcnv=%b required 0000", {zero_f, carry_f, negative_f, overflow_f});
      end
   endtask

   task automatic test_add_overflow();
      do_reset();
      issue(12'h47F, 0, 1'b0);
      issue(12'h001, 0, 1'b0);
      checks++;
      if (acc_out !== 8'h80 || {zero_f, carry_f, negative_f, overflow_f} !== 4'b0011) begin
         errors++;
         $display("FAIL add_overflow: acc=%h zcnv=%b required 80 0011", acc_out,
                  {zero_f, carry_f, negative_f, overflow_f});
      end
   endtask

   task automatic test_sub();
      do_reset();
      issue(12'h405, 0, 1'b0);
      issue(12'h105, 0, 1'b0);
      checks++;
      if (acc_out !== 8'h00 || zero_f !== 1'b1 || carry_f !== 1'b0) begin
         errors++;
         $display("FAIL sub_zero: acc=%h z=%b c=%b required 00 1 0", acc_out, zero_f, carry_f);
      end
      issue(12'h101, 0, 1'b0);
      checks++;
      if (acc_out !== 8'hFF || {zero_f, carry_f, negative_f, overflow_f} !== 4'b0110) begin
         errors++;
         $display("FAIL sub_borrow: acc=%h zcnv=%b required ff 0110", acc_out,
                  {zero_f, carry_f, negative_f, overflow_f});
      end
   endtask

   task automatic test_wait_states();
      int bad = 0;
      do_reset();
      instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (instr_req !== 1'b1 || fetch !== 1'b1 || instr_addr !== 4'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wait_hold: %0d bad cycles required 0", bad);
      end
      instr_valid = 1'b1;
      instr_data  = 12'h43C;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (acc_out !== 8'h00 || instr_addr !== 4'h0) begin
         errors++;
         $display("FAIL wait_early: acc=%h addr=%h required 00 0", acc_out, instr_addr);
      end
      @(negedge clk);
      checks++;
      if (acc_out !== 8'h3C || instr_addr !== 4'h1 || fetch !== 1'b1) begin
         errors++;
         $display("FAIL wait_commit: acc=%h addr=%h fetch=%b required 3c 1 1", acc_out, instr_addr, fetch);
      end
   endtask

   task automatic test_branch();
      logic [3:0] exp_addr;
      do_reset();
      issue(12'h400, 0, 1'b0);
      issue(12'h90C, 0, 1'b0);
      exp_addr = BR_EN ? 4'hC : 4'h2;
      checks++;
      if (instr_addr !== exp_addr) begin
         errors++;
         $display("FAIL branch_jz: addr=%h required %h", instr_addr, exp_addr);
      end
   endtask

   task automatic test_wrap_halt();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 15; i++) issue(12'hC00, 0, 1'b1);
      checks++;
      if (instr_addr !== 4'hF) begin
         errors++;
         $display("FAIL pc_top: addr=%h required f", instr_addr);
      end
      issue(12'hD00, 1, 1'b1);
      checks++;
      if (instr_addr !== 4'h0) begin
         errors++;
         $display("FAIL pc_wrap: addr=%h required 0", instr_addr);
      end
      issue(12'h455, 0, 1'b0);
      issue(12'hF00, 0, 1'b0);
      instr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instr_data = 12'($urandom);
         @(negedge clk);
         if (halted !== 1'b1 || instr_req !== 1'b0 || fetch !== 1'b0 || acc_out !== 8'h55) bad++;
      end
      instr_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_rst_in_decode();
      do_reset();
      issue(12'h410, 0, 1'b0);
      instr_valid = 1'b1;
      instr_data  = 12'h005;
      @(negedge clk);
      instr_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (acc_out !== 8'h00 || instr_addr !== 4'h0 || fetch !== 1'b1 ||
          {zero_f, carry_f, negative_f, overflow_f} !== 4'b0000) begin
         errors++;
         $display("FAIL rst_decode: acc=%h addr=%h fetch=%b zcnv=%b required 00 0 1 0000",
                  acc_out, instr_addr, fetch, {zero_f, carry_f, negative_f, overflow_f});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (acc_out !== 8'h00 || fetch !== 1'b1) begin
         errors++;
         $display("FAIL rst_no_commit: acc=%h fetch=%b required 00 1", acc_out, fetch);
      end
   endtask

   task automatic test_random();
      logic [11:0] ins;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         ins = {4'($urandom_range(0, 14)), 8'($urandom)};
         issue(ins, int'($urandom_range(0, 2)), 1'($urandom));
         checks++;
         if (acc_out !== 8'(m_acc) ||
             {zero_f, carry_f, negative_f, overflow_f} !== {m_z, m_c, m_n, m_v}) begin
            errors++;
            $display("FAIL rand_acc[%0d] ins=%h: acc=%h zcnv=%b required %h %b", i, ins, acc_out,
                     {zero_f, carry_f, negative_f, overflow_f}, 8'(m_acc), {m_z, m_c, m_n, m_v});
         end
         checks++;
         if (instr_addr !== 4'(m_pc) || halted !== 1'b0) begin
            errors++;
            $display("FAIL rand_pc[%0d] ins=%h: addr=%h halted=%b required %h 0", i, ins,
                     instr_addr, halted, 4'(m_pc));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_data = '0;
      test_reset();
      test_add_overflow();
      test_sub();
      test_wait_states();
      test_branch();
      test_wrap_halt();
      test_rst_in_decode();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acc_core.md
# acc_core

Parametrised accumulator processor core: a program counter, an instruction fetch handshake, a decode stage and a W-bit ALU with a registered flag file. It replaces the fixed 8-bit fetch/decode/execute accumulator datapath with one where the width and the program address space are set by parameters. It adds conditional branching and a halt state. It sits between an instruction source (ROM or switch bank) and the accumulator/flag status LEDs.

## Interface
- `W`, default 8: data width of the accumulator, the literal and the ALU; W ≥ 4.
- `AW`, default 4: program counter width; requires AW ≤ W.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `instr_req` output, 1 bit: high while the core is in FETCH.
- `instr_addr` output, AW bits: equals the PC; stable while `instr_req` is high.
- `instr_data` input, 4+W bits: {opcode[3:0], literal[W-1:0]}; sampled when `instr_req` & `instr_valid`.
- `instr_valid` input, 1 bit: instruction source has placed valid `instr_data`.
- `acc_out` output, W bits: accumulator contents.
- `zero_f`, `carry_f`, `negative_f`, `overflow_f` outputs, 1 bit each: registered flags.
- `fetch` output, 1 bit: high in the FETCH state (status LED).
- `halted` output, 1 bit: high in the HALT state.

## Operation
- States: FETCH, DECODE, EXECUTE, HALT. Encoding is free; only the state outputs are observable.
- FETCH: assert `instr_req`. On a cycle with `instr_valid`=1, latch opcode and literal into the IR and go to DECODE. Otherwise stay in FETCH with no bound on waiting.
- DECODE: one cycle. The ALU result and the branch decision are formed from the IR, ACC and flags. Next state is EXECUTE.
- EXECUTE: one cycle. Commit ACC, flags and PC, then go to FETCH. HLT goes to HALT instead.
- HALT: absorbing. Outputs are held and `instr_req` is 0. Only `rst` leaves HALT.
- Opcodes (L = literal, A = ACC):
  - 0 ADD: A+L.
  - 1 SUB: A−L.
  - 2 AND.
  - 3 OR.
  - 4 LDA: A=L.
  - 5 SHL: A<<1, 0 shifted in.
  - 6 SHR: logical A>>1.
  - 7 XOR.
  - 8 JMP.
  - 9 JZ.
  - 10 JC.
  - 11 JN.
  - 12–14 NOP.
  - 15 HLT.
- Flag rules for opcodes 0–7:
  - Z = (result == 0) and N = result[W-1], always updated.
  - ADD: C = carry out of bit W-1. V = operands share a sign and the result sign differs.
  - SUB: C = borrow (1 iff A < L, unsigned). V = operands differ in sign and the result sign differs from A.
  - All other ALU ops: C = 0, V = 0.
- Arithmetic is modulo 2^W; no saturation.
- Opcodes 8–15 leave ACC and flags unchanged.
- PC update in EXECUTE:
  - Taken branch: PC = L[AW-1:0].
  - Otherwise: PC+1, wrapping 2^AW−1 → 0.
  - A branch condition is evaluated on the flags as they stand before this instruction.

## Timing
- Reset values: state FETCH, PC 0, ACC 0, all four flags 0, IR 0. Consequently `instr_req`=1, `fetch`=1, `halted`=0 in the first cycle after `rst` deasserts.
- `rst` has priority over every event, including mid-FETCH and HALT. The core returns to the reset values on the next edge and any pending fetch is dropped.
- Instruction period: 3 cycles when `instr_valid` is high on the first FETCH cycle; each wait cycle adds 1.
- `acc_out` and the flags change on the edge that ends EXECUTE, exactly 2 edges after the accepting fetch edge.
- `instr_addr` changes only on the edge leaving EXECUTE.
- `instr_valid` outside FETCH is ignored.

## Configuration
- Macro: `ACC_CORE_BRANCH_EN`.
- Defined: opcodes 8–11 branch as specified above.
- Undefined: opcodes 8–11 decode as NOP (PC+1, ACC and flags unchanged), and no branch logic is synthesised.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use W=8 and AW=4.
- Reset, then program LDA 0x7F; ADD 0x01 with zero-wait valid → after 6 cycles ACC=0x80, N=1, V=1, C=0, Z=0.
- LDA 0x05; SUB 0x05; SUB 0x01 → after the second op ACC=0x00, Z=1, C=0. After the third ACC=0xFF, C=1, N=1, V=0.
- `instr_valid` held low 4 cycles in the first FETCH → `instr_req` and `fetch` stay 1, PC stays 0, and ACC updates on cycle 7, not cycle 3.
- With `ACC_CORE_BRANCH_EN`: LDA 0; JZ 0x0C → next `instr_addr`=0xC. Without the macro → `instr_addr`=0x2.
- PC at 0xF executing NOP → next `instr_addr`=0x0. HLT → `halted`=1 and `instr_req`=0 indefinitely.
- `rst` pulsed for 1 cycle during DECODE of ADD with ACC=0x10 → ACC=0, flags 0, PC 0, `fetch`=1 on the next cycle, and the ADD is never committed.
